score_tally: RTL and testbench

- Receiving end of the dropper scoring interface. Each dropper lane reports `done` when its note resolves and reports `score` as hit or miss.
- score_tally edge-detects those reports and classifies each note as hit or miss.
- Maintains total score, current combo, max combo, hit and miss counts, and end-of-song status.
- Sits between the dropper array and the HUD/text renderer; runs on frame_clk.

---
 rtl/score_tally.sv | 201 ++++++++++++++++++++
 tb/tb_score_tally.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_tally.sv
`default_nettype none
// ============================================================================
// Module      : score_tally
// Description : Scoring back end for the dropper lanes. Edge-detects each
//               lane's done level, classifies the resolved note as hit or
//               miss, and keeps total score, combo, max combo, hit/miss
//               counts and song state (IDLE / PLAY / SUMMARY).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   frame_clk   in   1        frame clock, one tick per video frame
//   Reset       in   1        synchronous active-high reset
//   keycode     in   8        USB keycode: 8'h2c start, 8'h01 back to idle
//   done_vec    in   N_LANES  per-lane level, high while dropper is in End
//   score_vec   in   N_LANES  per-lane hit flag, sampled when done rises
//   total_score out  16       accumulated points, saturating at SCORE_MAX
//   combo       out  8        consecutive hits since last miss (sat 255)
//   max_combo   out  8        highest combo this song
//   hit_count   out  8        hits this song (sat 255)
//   miss_count  out  8        misses this song (sat 255)
//   playing     out  1        high in PLAY
//   game_over   out  1        high in SUMMARY
//   grade       out  2        3=S 2=A 1=B 0=C, valid in SUMMARY
// Configuration:
//   SCORE_TALLY_GRADE_EN  when defined, grade is derived from the frozen
//                         counters in SUMMARY; otherwise grade is 0.
// ============================================================================
module score_tally #(
  parameter int          N_LANES      = 8,
  parameter int          BASE_PTS     = 10,
  parameter int          COMBO_THRESH = 5,
  parameter logic [15:0] SCORE_MAX    = 16'hFFFF
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [7:0]         keycode,
  input  logic [N_LANES-1:0] done_vec,
  input  logic [N_LANES-1:0] score_vec,
  output logic [15:0]        total_score,
  output logic [7:0]         combo,
  output logic [7:0]         max_combo,
  output logic [7:0]         hit_count,
  output logic [7:0]         miss_count,
  output logic               playing,
  output logic               game_over,
  output logic [1:0]         grade
);

  localparam int          c_cw      = $clog2(N_LANES + 1);
  localparam logic [31:0] c_thresh  = COMBO_THRESH;
  localparam logic [31:0] c_pts_lo  = BASE_PTS;
  localparam logic [31:0] c_pts_hi  = 2 * BASE_PTS;
  localparam logic [7:0]  c_key_go  = 8'h2c;
  localparam logic [7:0]  c_key_rtn = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_SUMMARY = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        total_q, total_d;
  logic [7:0]         combo_q, combo_d;
  logic [7:0]         max_q, max_d;
  logic [7:0]         hit_q, hit_d;
  logic [7:0]         miss_q, miss_d;
  logic [N_LANES-1:0] done_prev_q, done_prev_d;

  logic [N_LANES-1:0] w_rise;
  logic [c_cw-1:0]    w_nh, w_nm;
  logic [31:0]        w_pts, w_sum;
  logic [7:0]         w_combo_pk;

  function automatic logic [c_cw-1:0] popcnt(input logic [N_LANES-1:0] v);
    logic [c_cw-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_LANES; i++) begin
      cnt = cnt + {{(c_cw-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  function automatic logic [7:0] sat8(input logic [7:0] a, input logic [c_cw-1:0] n);
    logic [8:0] s;
    s = {1'b0, a} + 9'(n);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign w_rise     = done_vec & ~done_prev_q;
  assign w_nh       = popcnt(w_rise & score_vec);
  assign w_nm       = popcnt(w_rise & ~score_vec);
  // Every hit in a frame is priced off the combo held at the start of it.
  assign w_pts      = (32'(combo_q) >= c_thresh) ? c_pts_hi : c_pts_lo;
  assign w_sum      = 32'(total_q) + (32'(w_nh) * w_pts);
  // Peak combo including this frame's hits, before any miss clears it.
  assign w_combo_pk = sat8(combo_q, w_nh);

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      total_q     <= '0;
      combo_q     <= '0;
      max_q       <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      done_prev_q <= '0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      combo_q     <= combo_d;
      max_q       <= max_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      done_prev_q <= done_prev_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    combo_d     = combo_q;
    max_d       = max_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    // Tracking done_vec in every state means lanes already high when play
    // starts produce no rising edge.
    done_prev_d = done_vec;

    case (state_q)
      ST_IDLE: begin
        total_d = '0;
        combo_d = '0;
        max_d   = '0;
        hit_d   = '0;
        miss_d  = '0;
        if (keycode == c_key_go) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (keycode == c_key_rtn) begin
          state_d = ST_IDLE;
          total_d = '0;
          combo_d = '0;
          max_d   = '0;
          hit_d   = '0;
          miss_d  = '0;
        end else begin
          total_d = (w_sum > 32'(SCORE_MAX)) ? SCORE_MAX : w_sum[15:0];
          hit_d   = sat8(hit_q, w_nh);
          miss_d  = sat8(miss_q, w_nm);
          combo_d = (w_nm != '0) ? 8'd0 : w_combo_pk;
          max_d   = (w_combo_pk > max_q) ? w_combo_pk : max_q;
          if (&done_vec) state_d = ST_SUMMARY;
        end
      end
      ST_SUMMARY: begin
        if (keycode == c_key_rtn) begin
          state_d = ST_IDLE;
          total_d = '0;
          combo_d = '0;
          max_d   = '0;
          hit_d   = '0;
          miss_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign total_score = total_q;
  assign combo       = combo_q;
  assign max_combo   = max_q;
  assign hit_count   = hit_q;
  assign miss_count  = miss_q;
  assign playing     = (state_q == ST_PLAY);
  assign game_over   = (state_q == ST_SUMMARY);

`ifdef SCORE_TALLY_GRADE_EN
  logic [9:0] w_total;
  logic [9:0] w_miss4;
  logic [9:0] w_miss2;

  assign w_total = {2'b00, hit_q} + {2'b00, miss_q};
  assign w_miss4 = {miss_q, 2'b00};
  assign w_miss2 = {1'b0, miss_q, 1'b0};

  always_comb begin
    grade = 2'd0;
    if (game_over) begin
      if (miss_q == 8'd0 && w_total != 10'd0) grade = 2'd3;
      else if (w_miss4 <= w_total)            grade = 2'd2;
      else if (w_miss2 <= w_total)            grade = 2'd1;
      else                                    grade = 2'd0;
    end
  end
`else
  assign grade = 2'b00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_score_tally.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_tally
// Description : Self-checking bench for score_tally (4 lanes, BASE_PTS=10,
//               COMBO_THRESH=3). An integer-level song model predicts every
//               output each frame; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_tally;

  logic        frame_clk;
  logic        Reset;
  logic [7:0]  keycode;
  logic [3:0]  done_vec;
  logic [3:0]  score_vec;
  logic [15:0] total_score;
  logic [7:0]  combo, max_combo, hit_count, miss_count;
  logic        playing, game_over;
  logic [1:0]  grade;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 0;

  score_tally #(
    .N_LANES(4), .BASE_PTS(10), .COMBO_THRESH(3), .SCORE_MAX(16'hFFFF)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .done_vec(done_vec), .score_vec(score_vec),
    .total_score(total_score), .combo(combo), .max_combo(max_combo),
    .hit_count(hit_count), .miss_count(miss_count),
    .playing(playing), .game_over(game_over), .grade(grade)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // ---------------- behavioural song model ----------------
  int m_mode;   // 0 idle, 1 play, 2 summary
  int m_score, m_combo, m_max, m_hits, m_miss;
  bit [3:0] m_prev;

  task automatic m_clear();
    m_score = 0; m_combo = 0; m_max = 0; m_hits = 0; m_miss = 0;
  endtask

  always @(posedge frame_clk) begin
    if (Reset) begin
      m_mode = 0; m_clear(); m_prev = 4'h0;
    end else if (m_mode == 0) begin
      m_clear();
      if (keycode == 8'h2c) m_mode = 1;
      m_prev = done_vec;
    end else if (m_mode == 1) begin
      if (keycode == 8'h01) begin
        m_mode = 0; m_clear();
      end else begin
        int nh, nm, pts, peak;
        nh = 0; nm = 0;
        for (int i = 0; i < 4; i++)
          if (done_vec[i] && !m_prev[i]) begin
            if (score_vec[i]) nh++; else nm++;
          end
        pts     = (m_combo >= 3) ? 20 : 10;
        m_score = (m_score + nh * pts > 65535) ? 65535 : m_score + nh * pts;
        m_hits  = (m_hits + nh > 255) ? 255 : m_hits + nh;
        m_miss  = (m_miss + nm > 255) ? 255 : m_miss + nm;
        peak    = (m_combo + nh > 255) ? 255 : m_combo + nh;
        if (peak > m_max) m_max = peak;
        m_combo = (nm > 0) ? 0 : peak;
        if (done_vec == 4'hF) m_mode = 2;
      end
      m_prev = done_vec;
    end else begin
      if (keycode == 8'h01) begin
        m_mode = 0; m_clear();
      end
      m_prev = done_vec;
    end
  end

  function automatic int m_grade();
    int tot;
    tot = m_hits + m_miss;
`ifdef SCORE_TALLY_GRADE_EN
    if (m_mode != 2) return 0;
    if (m_miss == 0 && tot > 0) return 3;
    if (m_miss * 4 <= tot) return 2;
    if (m_miss * 2 <= tot) return 1;
    return 0;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge frame_clk) begin
    if (chk_en) begin
      check("cyc_total", int'(total_score), m_score);
      check("cyc_combo", int'(combo), m_combo);
      check("cyc_max", int'(max_combo), m_max);
      check("cyc_hits", int'(hit_count), m_hits);
      check("cyc_miss", int'(miss_count), m_miss);
      check("cyc_playing", int'(playing), (m_mode == 1) ? 1 : 0);
      check("cyc_gameover", int'(game_over), (m_mode == 2) ? 1 : 0);
      check("cyc_grade", int'(grade), m_grade());
    end
  end

  // ---------------- stimulus ----------------
  // Apply inputs, let one frame edge consume them, return just after it.
  task automatic frame(input logic [3:0] d, input logic [3:0] s, input logic [7:0] k);
    done_vec = d; score_vec = s; keycode = k;
    @(posedge frame_clk);
    #2;
  endtask

  int exp_grade_s;

  initial begin
`ifdef SCORE_TALLY_GRADE_EN
    exp_grade_s = 3;
`else
    exp_grade_s = 0;
`endif
    Reset = 1'b1;
    frame(4'h0, 4'h0, 8'h00);
    chk_en = 1;
    frame(4'h0, 4'h0, 8'h00);
    check("rst_total", int'(total_score), 0);
    check("rst_playing", int'(playing), 0);
    check("rst_hits", int'(hit_count), 0);
    Reset = 1'b0;

    // Song 1: four single-lane hits, last one at the doubled rate.
    frame(4'h0, 4'h0, 8'h00);
    frame(4'h0, 4'h0, 8'h2c);
    check("start_playing", int'(playing), 1);
    check("start_total", int'(total_score), 0);
    frame(4'h1, 4'hF, 8'h00);
    frame(4'h3, 4'hF, 8'h00);
    frame(4'h7, 4'hF, 8'h00);
    frame(4'hF, 4'hF, 8'h00);
    check("s1_total", int'(total_score), 50);
    check("s1_combo", int'(combo), 4);
    check("s1_max", int'(max_combo), 4);
    check("s1_hits", int'(hit_count), 4);
    check("s1_gameover", int'(game_over), 1);
    check("s1_grade", int'(grade), exp_grade_s);

    // Edges in SUMMARY are ignored.
    frame(4'h0, 4'hF, 8'h00);
    frame(4'h1, 4'hF, 8'h00);
    check("sum_frozen_total", int'(total_score), 50);
    check("sum_frozen_hits", int'(hit_count), 4);
    frame(4'h1, 4'hF, 8'h01);
    check("rtn_gameover", int'(game_over), 0);
    check("rtn_total", int'(total_score), 0);

    // Song 2: lanes already high at start give no event; then hit+miss frame.
    frame(4'h3, 4'hF, 8'h00);
    frame(4'h3, 4'hF, 8'h2c);
    frame(4'h3, 4'hF, 8'h00);
    check("prehigh_hits", int'(hit_count), 0);
    frame(4'h0, 4'hF, 8'h00);
    frame(4'h1, 4'hF, 8'h00);
    frame(4'h0, 4'hF, 8'h00);
    frame(4'h2, 4'hF, 8'h00);
    frame(4'h0, 4'hF, 8'h00);
    frame(4'h4, 4'hF, 8'h00);
    check("s2_combo3", int'(combo), 3);
    frame(4'h7, 4'h1, 8'h00);
    check("mix_total", int'(total_score), 50);
    check("mix_combo", int'(combo), 0);
    check("mix_max", int'(max_combo), 4);
    check("mix_hits", int'(hit_count), 4);
    check("mix_miss", int'(miss_count), 1);

    // Reset in the middle of a song.
    Reset = 1'b1;
    frame(4'h0, 4'h0, 8'h00);
    Reset = 1'b0;
    frame(4'h0, 4'h0, 8'h2c);
    frame(4'h1, 4'hF, 8'h00);
    frame(4'h3, 4'hF, 8'h00);
    check("mid_hits2", int'(hit_count), 2);
    Reset = 1'b1;
    frame(4'h3, 4'hF, 8'h00);
    check("midrst_hits", int'(hit_count), 0);
    check("midrst_total", int'(total_score), 0);
    check("midrst_playing", int'(playing), 0);
    Reset = 1'b0;

    // Saturation run: 30 + 1091*60 + 2*20 = 65530.
    frame(4'h0, 4'h0, 8'h00);
    frame(4'h0, 4'h0, 8'h2c);
    frame(4'h7, 4'hF, 8'h00);
    frame(4'h0, 4'hF, 8'h00);
    check("sat_first", int'(total_score), 30);
    repeat (1091) begin
      frame(4'h7, 4'hF, 8'h00);
      frame(4'h0, 4'hF, 8'h00);
    end
    repeat (2) begin
      frame(4'h1, 4'hF, 8'h00);
      frame(4'h0, 4'hF, 8'h00);
    end
    check("sat_65530", int'(total_score), 65530);
    check("sat_hits255", int'(hit_count), 255);
    check("sat_combo255", int'(combo), 255);
    frame(4'h1, 4'hF, 8'h00);
    check("sat_clip", int'(total_score), 65535);
    frame(4'h0, 4'hF, 8'h00);
    frame(4'h1, 4'hF, 8'h00);
    check("sat_hold", int'(total_score), 65535);
    frame(4'hF, 4'hF, 8'h00);
    check("sat_gameover", int'(game_over), 1);
    check("sat_grade", int'(grade), exp_grade_s);
    frame(4'h0, 4'h0, 8'h01);
    check("end_idle_total", int'(total_score), 0);
    frame(4'h0, 4'h0, 8'h00);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
